// File: rtl/openfire_mem_arbiter_pkg.sv
// openfire_mem_arbiter_pkg: shared encodings for the instruction/data memory arbiter.
// Rev 1.0 - initial release
`default_nettype none

package openfire_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IBUS = 2'd1,
    ARB_DBUS = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  // OpenFire no-operation encoding, fed to fetch after reset or an aborted fetch
  localparam logic [31:0] NOOP = 32'h8000_0000;

  // Winner for a non-empty request set: a lone requester wins, otherwise the loser of last time
  function automatic grant_e pick_grant(input logic i_elig, input logic d_elig, input grant_e last);
    if (i_elig && (!d_elig || last == GRANT_DATA)) begin
      return GRANT_INSTR;
    end
    return GRANT_DATA;
  endfunction

endpackage

`default_nettype wire

// File: rtl/openfire_mem_arbiter_watchdog.sv
// openfire_bus_watchdog: counts active bus cycles and pulses expire on the TIMEOUT-th one.
// Rev 1.0 - initial release
`default_nettype none

module openfire_bus_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] SAT  = {TO_W{1'b1}};

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q != SAT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // First active cycle sees a count of 0, so the TIMEOUT-th active cycle sees LAST
  assign expire = (TIMEOUT != 0) && enable && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/openfire_mem_arbiter.sv
// openfire_mem_arbiter: round-robin sharing of one memory bus between fetch and execute.
// Rev 1.0 - initial release
`default_nettype none

module openfire_mem_arbiter
  import openfire_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_data,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_sel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              bus_err,
  output logic              i_stall,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       i_data_q, i_data_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              bus_err_q, bus_err_d;

  logic              i_elig;
  logic              d_elig;
  logic              wd_clear;
  logic              wd_expire;
  grant_e            grant;

  // A requester still holds its level during its done pulse; that level is stale
  assign i_elig = i_req && !i_done_q;
  assign d_elig = d_req && !d_done_q;
  assign grant  = pick_grant(i_elig, d_elig, last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_sel_d    = mem_sel_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_data_d     = i_data_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    bus_err_d    = 1'b0;
    wd_clear     = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (i_elig || d_elig) begin
          mem_req_d    = 1'b1;
          wd_clear     = 1'b1;
          last_grant_d = grant;
          if (grant == GRANT_INSTR) begin
            state_d     = ARB_IBUS;
            mem_addr_d  = i_addr & WORD_MASK;
            mem_we_d    = 1'b0;
            mem_sel_d   = 4'b1111;
            mem_wdata_d = '0;
          end else begin
            state_d     = ARB_DBUS;
            mem_addr_d  = d_addr & WORD_MASK;
            mem_we_d    = d_we;
            mem_sel_d   = d_sel;
            mem_wdata_d = d_wdata;
          end
        end
      end

      ARB_IBUS, ARB_DBUS: begin
        // An ack arriving with the watchdog expiry still counts as a normal completion
        if (mem_ack || wd_expire) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = !mem_ack;
          if (state_q == ARB_IBUS) begin
            i_done_d = 1'b1;
            i_data_d = mem_ack ? mem_rdata : NOOP;
          end else begin
            d_done_d = 1'b1;
            if (!mem_ack) begin
              d_rdata_d = '0;
            end else if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end
      end

      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_INSTR;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_data_q     <= NOOP;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_data_q     <= i_data_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      bus_err_q    <= bus_err_d;
    end
  end

  openfire_bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (state_q != ARB_IDLE),
    .expire (wd_expire)
  );

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_data    = i_data_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign bus_err   = bus_err_q;
  assign i_stall   = i_req && !i_done_q;
  assign d_stall   = d_req && !d_done_q;

endmodule

`default_nettype wire
